// File: rtl/video_write_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : video_write_scheduler                                         |
// | Purpose  : Owns the video memory write port. Shares it between a host    |
// |            write port (valid/ready) and an internal fill engine that     |
// |            writes one masked value over a run of cells. At most one      |
// |            write per clock; video_* outputs are registered.              |
// | Ports    : clk, reset (sync, active-high)                                |
// |            host_valid/host_ready/host_address/host_value/host_mask       |
// |            fill_start/fill_base/fill_count/fill_value/fill_mask          |
// |            fill_abort (only with VIDEO_FILL_ABORT_EN)                    |
// |            fill_busy, fill_done                                          |
// |            video_write/video_address/video_value/video_mask              |
// | Config   : `define VIDEO_FILL_ABORT_EN adds the fill_abort input.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module video_write_scheduler #(
  parameter int CELLS  = 2000,
  parameter int ATTR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [15:0]       host_address,
  input  logic [ATTR_W-1:0] host_value,
  input  logic [ATTR_W-1:0] host_mask,
  input  logic              fill_start,
  input  logic [15:0]       fill_base,
  input  logic [15:0]       fill_count,
  input  logic [ATTR_W-1:0] fill_value,
  input  logic [ATTR_W-1:0] fill_mask,
`ifdef VIDEO_FILL_ABORT_EN
  input  logic              fill_abort,
`endif
  output logic              fill_busy,
  output logic              fill_done,
  output logic              video_write,
  output logic [15:0]       video_address,
  output logic [ATTR_W-1:0] video_value,
  output logic [ATTR_W-1:0] video_mask
);

  localparam logic [15:0] CELLS_W = 16'(CELLS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;
  typedef enum logic [0:0] {GRANT_HOST = 1'b0, GRANT_FILL = 1'b1} grant_t;

  state_t              state, state_next;
  grant_t              last_grant;

  logic [15:0]         fill_addr;    // current fill cell, already wrapped into 0..CELLS-1
  logic [15:0]         index;
  logic [15:0]         count;
  logic [ATTR_W-1:0]   latched_value;
  logic [ATTR_W-1:0]   latched_mask;

  logic                abort_req;
  logic                host_grant;
  logic                fill_grant;
  logic                fill_latch;
  logic                done_next;

`ifdef VIDEO_FILL_ABORT_EN
  assign abort_req = fill_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign fill_busy = (state == S_FILL);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and arbitration
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    host_grant = 1'b0;
    fill_grant = 1'b0;
    fill_latch = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        host_ready = 1'b1;
        host_grant = host_valid;
        if (fill_start) begin
          if (fill_count == 16'd0) begin
            // Empty fill: nothing to write, just report completion.
            done_next = 1'b1;
          end else begin
            fill_latch = 1'b1;
            state_next = S_FILL;
          end
        end
      end
      S_FILL: begin
        // Round-robin: the host may only go if the fill had the last slot.
        host_ready = (last_grant == GRANT_FILL);
        host_grant = host_valid && (last_grant == GRANT_FILL);
        fill_grant = !host_grant && !abort_req;
        if (abort_req || (fill_grant && (index == count - 16'd1))) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath, fill bookkeeping and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant    <= GRANT_HOST;
      fill_done     <= 1'b0;
      video_write   <= 1'b0;
      video_address <= 16'd0;
      video_value   <= '0;
      video_mask    <= '0;
      fill_addr     <= 16'd0;
      index         <= 16'd0;
      count         <= 16'd0;
      latched_value <= '0;
      latched_mask  <= '0;
    end else begin
      fill_done   <= done_next;
      video_write <= 1'b0;

      // Out-of-range host writes complete the handshake but are dropped.
      if (host_grant && (host_address < CELLS_W)) begin
        video_write   <= 1'b1;
        video_address <= host_address;
        video_value   <= host_value;
        video_mask    <= host_mask;
      end else if (fill_grant) begin
        video_write   <= 1'b1;
        video_address <= fill_addr;
        video_value   <= latched_value;
        video_mask    <= latched_mask;
      end

      if (fill_latch) begin
        // Reduce the base once here so later steps only need a single wrap test.
        fill_addr     <= 16'(fill_base % CELLS_W);
        index         <= 16'd0;
        count         <= fill_count;
        latched_value <= fill_value;
        latched_mask  <= fill_mask;
        last_grant    <= GRANT_HOST;
      end

      if (state == S_FILL) begin
        if (host_grant) begin
          last_grant <= GRANT_HOST;
        end else if (fill_grant) begin
          last_grant <= GRANT_FILL;
          index      <= index + 16'd1;
          fill_addr  <= (fill_addr == CELLS_W - 16'd1) ? 16'd0 : fill_addr + 16'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
